// File: rtl/mem_arb_pkg.sv
// Shared types for the unified I/D memory arbiter.
// The optional fairness feature is selected by MEM_ARB_FAIRNESS_EN (see mem_arb_pick).
package mem_arb_pkg;

  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned BE_W       = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    IDROP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner picker: fixed data priority, or alternation on collisions
// when MEM_ARB_FAIRNESS_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic ireq,
  input  logic dreq,
  input  logic last_owner,
  output logic grant_valid,
  output logic owner
);

  always_comb begin
    grant_valid = ireq | dreq;
    owner       = OWN_I;
`ifdef MEM_ARB_FAIRNESS_EN
    // On a collision hand the memory to whoever did not own the last grant.
    if (ireq && dreq) begin
      owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (dreq) begin
      owner = OWN_D;
    end
`else
    if (dreq) begin
      owner = OWN_D;
    end
`endif
  end

`ifndef MEM_ARB_FAIRNESS_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported I/D memory arbiter: one outstanding transaction, fetch-kill support.
// Define MEM_ARB_FAIRNESS_EN to alternate owners when both stages collide.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                IReqF,
  input  logic [ADDR_W-1:0]   IAddrF,
  input  logic                IKillF,
  output logic                IReadyF,
  output logic [DATA_W-1:0]   IRdataF,
  input  logic                DReqM,
  input  logic                DWeM,
  input  logic [ADDR_W-1:0]   DAddrM,
  input  logic [DATA_W-1:0]   DWdataM,
  input  logic [DATA_W/8-1:0] DBeM,
  output logic                DReadyM,
  output logic [DATA_W-1:0]   DRdataM,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                StallMemF,
  output logic                StallMemM
);

  localparam int unsigned BW = DATA_W / 8;

  arb_state_e state;
  logic       ireq_pend;
  logic       pick_valid;
  logic       pick_owner;
  logic       sel_valid;
  logic       sel_owner;
  logic       issue;
  logic       lock_vld;
  logic       lock_own;
  logic       last_owner;

  assign ireq_pend = IReqF & ~IKillF;

  mem_arb_pick u_pick (
    .ireq        (ireq_pend),
    .dreq        (DReqM),
    .last_owner  (last_owner),
    .grant_valid (pick_valid),
    .owner       (pick_owner)
  );

  // A request still waiting for mem_gnt keeps its owner so the mem_* fields stay stable.
  always_comb begin
    sel_valid = pick_valid;
    sel_owner = pick_owner;
    if (lock_vld) begin
      sel_owner = lock_own;
      sel_valid = (lock_own == OWN_D) ? DReqM : ireq_pend;
    end
  end

  assign issue = (state == IDLE) && sel_valid;

  // Memory request fields; zero whenever nothing is being requested.
  always_comb begin
    mem_req   = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (issue) begin
      if (sel_owner == OWN_D) begin
        mem_we    = DWeM;
        mem_addr  = DAddrM;
        mem_wdata = DWdataM;
        mem_be    = DWeM ? DBeM : {BW{1'b1}};
      end else begin
        mem_addr  = IAddrF;
        mem_be    = {BW{1'b1}};
      end
    end
  end

  // Responses pass straight through; a kill in the response cycle swallows the fetch.
  assign IReadyF   = (state == IBUSY) && mem_rvalid && !IKillF;
  assign DReadyM   = (state == DBUSY) && mem_rvalid;
  assign IRdataF   = mem_rdata;
  assign DRdataM   = mem_rdata;
  assign StallMemF = IReqF & ~IReadyF & ~IKillF;
  assign StallMemM = DReqM & ~DReadyM;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lock_vld   <= 1'b0;
      lock_own   <= OWN_I;
      last_owner <= OWN_I;
    end else begin
      case (state)
        IDLE: begin
          if (issue && mem_gnt) begin
            state      <= (sel_owner == OWN_D) ? DBUSY : IBUSY;
            last_owner <= sel_owner;
            lock_vld   <= 1'b0;
          end else begin
            lock_vld <= issue;
            lock_own <= sel_owner;
          end
        end
        IBUSY: begin
          if (mem_rvalid) begin
            state <= IDLE;
          end else if (IKillF) begin
            state <= IDROP;
          end
        end
        DBUSY: begin
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        IDROP: begin
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level memory and requester model.
module tb_mem_arbiter;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IReqF, IKillF, IReadyF;
  logic [31:0] IAddrF, IRdataF;
  logic        DReqM, DWeM, DReadyM;
  logic [31:0] DAddrM, DWdataM, DRdataM;
  logic [3:0]  DBeM;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        StallMemF, StallMemM;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] phys  [logic [31:0]];
  logic [31:0] ref_m [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .IReqF(IReqF), .IAddrF(IAddrF), .IKillF(IKillF), .IReadyF(IReadyF), .IRdataF(IRdataF),
    .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM), .DBeM(DBeM),
    .DReadyM(DReadyM), .DRdataM(DRdataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .StallMemF(StallMemF), .StallMemM(StallMemM)
  );

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[7:0], 24'h0};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic drive_idle();
    IReqF = 0; IAddrF = 0; IKillF = 0;
    DReqM = 0; DWeM = 0; DAddrM = 0; DWdataM = 0; DBeM = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    #12;
    if ({mem_req, mem_we, mem_be, IReadyF, DReadyM, StallMemF, StallMemM} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_be, IReadyF, DReadyM, StallMemF, StallMemM});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", {mem_addr, mem_wdata});
    end
    n_cmp++;
    DReqM = 1'b1;
    #1;
    if (StallMemM !== 1'b1) begin
      n_fail++; $display("FAIL reset_stallm: got %b want 1", StallMemM);
    end
    n_cmp++;
    DReqM = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fetch_only();
    int stalls = 0;
    @(negedge clk);
    IReqF = 1; IAddrF = 32'h100; mem_gnt = 1;
    #1;
    stalls += int'(StallMemF);
    if ({mem_req, mem_we, mem_be, IReadyF} !== 7'b1_0_1111_0 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL fetch_req: got %b/%h want 1011110/100", {mem_req, mem_we, mem_be, IReadyF}, mem_addr);
    end
    n_cmp++;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    #1;
    stalls += int'(StallMemF);
    if (IReadyF !== 1'b1 || IRdataF !== 32'h0050_0093 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL fetch_rsp: got %b/%h/%b want 1/00500093/0", IReadyF, IRdataF, mem_req);
    end
    n_cmp++;
    @(negedge clk);
    IReqF = 0; mem_rvalid = 0;
    #1;
    if (IReadyF !== 1'b0 || stalls != 1) begin
      n_fail++; $display("FAIL fetch_pulse: got ready=%b stalls=%0d want 0/1", IReadyF, stalls);
    end
    n_cmp++;
  endtask

  task automatic test_collision();
    @(negedge clk);
    IReqF = 1; IAddrF = 32'h104; DReqM = 1; DWeM = 0; DAddrM = 32'h2000; DBeM = 4'h0; mem_gnt = 1;
    #1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0 || mem_be !== 4'hf) begin
      n_fail++; $display("FAIL coll_first: got %b/%h/%b/%h want 1/2000/0/f", mem_req, mem_addr, mem_we, mem_be);
    end
    n_cmp++;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
    #1;
    if ({IReadyF, DReadyM, StallMemF, StallMemM} !== 4'b0110 || DRdataM !== 32'h1111_1111) begin
      n_fail++; $display("FAIL coll_drsp: got %b/%h want 0110/11111111", {IReadyF, DReadyM, StallMemF, StallMemM}, DRdataM);
    end
    n_cmp++;
    @(negedge clk);
    DAddrM = 32'h2004; mem_rvalid = 0; mem_gnt = 1;
    #1;
    if (mem_addr !== (FAIR ? 32'h104 : 32'h2004)) begin
      n_fail++; $display("FAIL coll_second: got %h want %h", mem_addr, FAIR ? 32'h104 : 32'h2004);
    end
    n_cmp++;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h2222_2222;
    #1;
    if ({IReadyF, DReadyM} !== {FAIR, !FAIR}) begin
      n_fail++; $display("FAIL coll_rsp2: got %b want %b", {IReadyF, DReadyM}, {FAIR, !FAIR});
    end
    n_cmp++;
    @(negedge clk);
    IReqF = FAIR ? 1'b0 : 1'b1;
    DReqM = FAIR ? 1'b1 : 1'b0;
    mem_rvalid = 0; mem_gnt = 1;
    #1;
    if (mem_addr !== (FAIR ? 32'h2004 : 32'h104)) begin
      n_fail++; $display("FAIL coll_third: got %h want %h", mem_addr, FAIR ? 32'h2004 : 32'h104);
    end
    n_cmp++;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h3333_3333;
    #1;
    if ({IReadyF, DReadyM} !== {!FAIR, FAIR}) begin
      n_fail++; $display("FAIL coll_rsp3: got %b want %b", {IReadyF, DReadyM}, {!FAIR, FAIR});
    end
    n_cmp++;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_store_wait();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      DReqM = 1; DWeM = 1; DAddrM = 32'h3000; DWdataM = 32'h0000_BEEF; DBeM = 4'b0011;
      IReqF = (c >= 1); IAddrF = 32'h108;
      mem_gnt = (c == 3);
      #1;
      if ({mem_req, mem_we, mem_be, StallMemM, DReadyM} !== 8'b1_1_0011_1_0 ||
          mem_addr !== 32'h3000 || mem_wdata !== 32'h0000_BEEF) begin
        n_fail++;
        $display("FAIL store_hold%0d: got %b/%h/%h want 11001110/3000/0000beef", c,
                 {mem_req, mem_we, mem_be, StallMemM, DReadyM}, mem_addr, mem_wdata);
      end
      n_cmp++;
    end
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_0000;
    #1;
    if ({DReadyM, StallMemM, IReadyF} !== 3'b100) begin
      n_fail++; $display("FAIL store_done: got %b want 100", {DReadyM, StallMemM, IReadyF});
    end
    n_cmp++;
    @(negedge clk);
    DReqM = 0; mem_rvalid = 0; mem_gnt = 1;
    #1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin
      n_fail++; $display("FAIL store_then_fetch: got %b/%h want 1/108", mem_req, mem_addr);
    end
    n_cmp++;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_kill();
    @(negedge clk);
    IReqF = 1; IAddrF = 32'h200; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; IKillF = 1;
    #1;
    if ({IReadyF, StallMemF} !== 2'b00) begin
      n_fail++; $display("FAIL kill_cycle: got %b want 00", {IReadyF, StallMemF});
    end
    n_cmp++;
    @(negedge clk);
    IKillF = 0; IAddrF = 32'h300; mem_gnt = 1;
    #1;
    if ({mem_req, StallMemF} !== 2'b01) begin
      n_fail++; $display("FAIL kill_drop_noreq: got %b want 01", {mem_req, StallMemF});
    end
    n_cmp++;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    if ({mem_req, IReadyF} !== 2'b00) begin
      n_fail++; $display("FAIL kill_discard: got %b want 00", {mem_req, IReadyF});
    end
    n_cmp++;
    @(negedge clk);
    mem_rvalid = 0; mem_gnt = 1;
    #1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
      n_fail++; $display("FAIL kill_refetch: got %b/%h want 1/300", mem_req, mem_addr);
    end
    n_cmp++;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_CAFE;
    #1;
    if (IReadyF !== 1'b1 || IRdataF !== 32'h0000_CAFE) begin
      n_fail++; $display("FAIL kill_refetch_rsp: got %b/%h want 1/0000cafe", IReadyF, IRdataF);
    end
    n_cmp++;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    DReqM = 1; DWeM = 0; DAddrM = 32'h4000; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    #1;
    reset_n = 0; DReqM = 0;
    #1;
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    #1;
    if ({DReadyM, IReadyF, mem_req, mem_we, mem_be} !== 7'b0) begin
      n_fail++; $display("FAIL rst_mid: got %b want 0", {DReadyM, IReadyF, mem_req, mem_we, mem_be});
    end
    n_cmp++;
    @(negedge clk);
    reset_n = 1;
    #1;
    if ({DReadyM, IReadyF, mem_req} !== 3'b000) begin
      n_fail++; $display("FAIL stray_rvalid: got %b want 000", {DReadyM, IReadyF, mem_req});
    end
    n_cmp++;
    @(negedge clk);
    mem_rvalid = 0; IReqF = 1; IAddrF = 32'h500; mem_gnt = 1;
    #1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
      n_fail++; $display("FAIL rst_recover: got %b/%h want 1/500", mem_req, mem_addr);
    end
    n_cmp++;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_random();
    bit          busy = 0, fire, req_open = 0, last_d = 0, drop_i = 0, drop_d = 0, own_d, exp_i, exp_d;
    int          cnt = 0, fwait = 0, dwait = 0, n_done = 0;
    logic [31:0] t_addr = 0, t_wdata = 0, prev_addr = 0, a;
    logic [3:0]  t_be = 0;
    bit          t_we = 0, t_own_d = 0;
    @(negedge clk);
    drive_idle();
    reset_n = 0;
    #2 reset_n = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (drop_i) IReqF = 0;
      if (drop_d) DReqM = 0;
      drop_i = 0; drop_d = 0;
      if (!IReqF && $urandom_range(0, 2) == 0) begin
        IReqF = 1; IAddrF = 32'($urandom_range(0, 15)) * 4; fwait = 0;
      end
      if (!DReqM && $urandom_range(0, 2) == 0) begin
        DReqM = 1; DWeM = 1'($urandom_range(0, 1)); DAddrM = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        DWdataM = $urandom; DBeM = 4'($urandom); dwait = 0;
      end
      fire = busy && (cnt == 0);
      mem_rvalid = fire;
      if (fire && !t_we) mem_rdata = phys.exists(t_addr) ? phys[t_addr] : init_val(t_addr);
      else mem_rdata = $urandom;
      if (fire && t_we) phys[t_addr] = merge(phys.exists(t_addr) ? phys[t_addr] : init_val(t_addr), t_wdata, t_be);
      mem_gnt = !busy && ($urandom_range(0, 2) != 0);
      #1;
      exp_i = fire && !t_own_d;
      exp_d = fire && t_own_d;
      if ({IReadyF, DReadyM, StallMemF, StallMemM} !== {exp_i, exp_d, IReqF && !exp_i, DReqM && !exp_d}) begin
        n_fail++;
        $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, {IReadyF, DReadyM, StallMemF, StallMemM},
                 {exp_i, exp_d, IReqF && !exp_i, DReqM && !exp_d});
      end
      n_cmp++;
      if (exp_i) begin
        a = IAddrF;
        if (IRdataF !== (ref_m.exists(a) ? ref_m[a] : init_val(a))) begin
          n_fail++; $display("FAIL rnd_fetch_data @%h: got %h want %h", a, IRdataF, ref_m.exists(a) ? ref_m[a] : init_val(a));
        end
        n_cmp++;
        drop_i = 1; n_done++;
      end
      if (exp_d) begin
        a = DAddrM;
        if (DWeM) begin
          ref_m[a] = merge(ref_m.exists(a) ? ref_m[a] : init_val(a), DWdataM, DBeM);
        end else begin
          if (DRdataM !== (ref_m.exists(a) ? ref_m[a] : init_val(a))) begin
            n_fail++; $display("FAIL rnd_load_data @%h: got %h want %h", a, DRdataM, ref_m.exists(a) ? ref_m[a] : init_val(a));
          end
          n_cmp++;
        end
        drop_d = 1; n_done++;
      end
      if (busy) begin
        if (mem_req !== 1'b0) begin
          n_fail++; $display("FAIL rnd_req_busy cyc%0d: got %b want 0", cyc, mem_req);
        end
        n_cmp++;
      end else if (mem_req) begin
        own_d = mem_addr[12];
        if (req_open) begin
          if (mem_addr !== prev_addr) begin
            n_fail++; $display("FAIL rnd_stable cyc%0d: got %h want %h", cyc, mem_addr, prev_addr);
          end
          n_cmp++;
        end else if (IReqF && DReqM) begin
          if (own_d !== (FAIR ? !last_d : 1'b1)) begin
            n_fail++; $display("FAIL rnd_priority cyc%0d: got own_d=%b want %b", cyc, own_d, FAIR ? !last_d : 1'b1);
          end
          n_cmp++;
        end
        if (own_d) begin
          if ({mem_addr, mem_we, mem_wdata, mem_be} !== {DAddrM, DWeM, DWdataM, DWeM ? DBeM : 4'hf}) begin
            n_fail++; $display("FAIL rnd_dfields: got %h/%b/%h/%h want %h/%b/%h/%h", mem_addr, mem_we, mem_wdata, mem_be,
                               DAddrM, DWeM, DWdataM, DWeM ? DBeM : 4'hf);
          end
        end else begin
          if ({mem_addr, mem_we, mem_be} !== {IAddrF, 1'b0, 4'hf}) begin
            n_fail++; $display("FAIL rnd_ifields: got %h/%b/%h want %h/0/f", mem_addr, mem_we, mem_be, IAddrF);
          end
        end
        n_cmp++;
        prev_addr = mem_addr;
        if (mem_gnt) begin
          busy = 1; cnt = $urandom_range(0, 2); last_d = own_d; req_open = 0;
          t_own_d = own_d; t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata; t_be = mem_be;
        end else begin
          req_open = 1;
        end
      end else begin
        req_open = 0;
      end
      if (fire) busy = 0;
      else if (busy && !(mem_req && mem_gnt)) cnt--;
      if (IReqF && !exp_i) fwait++;
      if (DReqM && !exp_d) dwait++;
      if (fwait > 80 || dwait > 80) begin
        n_fail++; n_cmp++;
        $display("FAIL rnd_timeout cyc%0d: got fwait=%0d dwait=%0d want <=80", cyc, fwait, dwait);
        break;
      end
    end
    if (n_done < 50) begin
      n_fail++; $display("FAIL rnd_progress: got %0d want >=50", n_done);
    end
    n_cmp++;
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_collision();
    test_store_wait();
    test_kill();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
